// File: rtl/disparity_depth_conv_if.sv
// Handshake bundle for the disparity-to-depth converter: the upstream
// disparity strobe (no backpressure) and the downstream valid/ready result.
interface disparity_depth_conv_if #(
  parameter int QW = 16
) ();

  // Upstream: best-match disparity from the comparator tree
  logic [7:0]    d_in;
  logic          d_valid;

  // Downstream: depth result with valid/ready handshake
  logic [QW-1:0] depth;
  logic [7:0]    depth_d;
  logic          depth_sat;
  logic          depth_zero;
  logic          depth_valid;
  logic          depth_ready;

  // Sticky status: a pending disparity was overwritten
  logic          overrun;

  // Environment side: produces disparities, consumes depth results
  modport master (
    output d_in, d_valid, depth_ready,
    input  depth, depth_d, depth_sat, depth_zero, depth_valid, overrun
  );

  // Converter side
  modport slave (
    input  d_in, d_valid, depth_ready,
    output depth, depth_d, depth_sat, depth_zero, depth_valid, overrun
  );

endinterface

// File: rtl/disparity_depth_conv.sv
// Disparity-to-depth converter: depth = floor(K / d) computed by a bit-serial
// restoring divider (one quotient bit per cycle). A one-entry pending slot
// absorbs disparities that arrive while a conversion is busy or its result is
// still waiting for the consumer; the newest disparity wins on collision.
module disparity_depth_conv #(
  parameter int K_WIDTH = 24,
  parameter int K_VALUE = 245760,
  parameter int QW      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  disparity_depth_conv_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int                 CNT_W     = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;
  localparam logic [K_WIDTH-1:0] K_CONST   = K_WIDTH'(K_VALUE);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(K_WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [QW-1:0]      DEPTH_MAX = '1;

  // Control state
  logic [1:0]         state_q,      state_d;
  logic [7:0]         pend_disp_q,  pend_disp_d;
  logic               pend_v_q,     pend_v_d;
  logic               overrun_q,    overrun_d;

  // Divider datapath
  logic [8:0]         rem_q,        rem_d;
  logic [K_WIDTH-1:0] dvd_q,        dvd_d;
  logic [7:0]         div_q,        div_d;
  logic [K_WIDTH-1:0] quo_q,        quo_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;

  // Result registers
  logic [QW-1:0]      depth_q,      depth_d;
  logic [7:0]         depth_disp_q, depth_disp_d;
  logic               sat_q,        sat_d;
  logic               zero_q,       zero_d;
  logic               valid_q,      valid_d;

  // One divider step
  logic [8:0]         rem_shift;
  logic [8:0]         rem_next;
  logic               q_bit;
  logic [K_WIDTH-1:0] quo_shift;
  logic               quo_overflow;

  // Conversion launch request
  logic               start;
  logic [7:0]         start_disp;

  // One restoring-division iteration: shift in the next dividend bit, subtract if it fits
  always_comb begin
    // The remainder is always below the divisor (< 256), so its top bit is
    // zero and dropping the MSB of the 10-bit shifted value loses nothing.
    rem_shift = 9'({rem_q, dvd_q[K_WIDTH-1]});
    if (rem_shift >= {1'b0, div_q}) begin
      rem_next = rem_shift - {1'b0, div_q};
      q_bit    = 1'b1;
    end else begin
      rem_next = rem_shift;
      q_bit    = 1'b0;
    end
    quo_shift    = K_WIDTH'({quo_q, q_bit});
    quo_overflow = (quo_shift >> QW) != '0;
  end

  // Next-state logic: sequencing, pending-slot capture and conversion launch
  always_comb begin
    // NOTE: every next-state signal first takes its current value so that no
    // path through the case below leaves it unassigned and infers a latch.
    state_d      = state_q;
    pend_disp_d  = pend_disp_q;
    pend_v_d     = pend_v_q;
    overrun_d    = overrun_q;
    rem_d        = rem_q;
    dvd_d        = dvd_q;
    div_d        = div_q;
    quo_d        = quo_q;
    cnt_d        = cnt_q;
    depth_d      = depth_q;
    depth_disp_d = depth_disp_q;
    sat_d        = sat_q;
    zero_d       = zero_q;
    valid_d      = valid_q;
    start        = 1'b0;
    start_disp   = bus.d_in;

    case (state_q)
      S_IDLE: begin
        if (bus.d_valid) begin
          start = 1'b1;
        end
      end

      S_DIV: begin
        rem_d = rem_next;
        dvd_d = {dvd_q[K_WIDTH-2:0], 1'b0};
        quo_d = quo_shift;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // Last quotient bit just resolved: publish the (possibly saturated) result
          state_d      = S_DONE;
          valid_d      = 1'b1;
          depth_disp_d = div_q;
          zero_d       = 1'b0;
          if (quo_overflow) begin
            depth_d = DEPTH_MAX;
            sat_d   = 1'b1;
          end else begin
            depth_d = quo_shift[QW-1:0];
            sat_d   = 1'b0;
          end
        end
        if (bus.d_valid) begin
          pend_disp_d = bus.d_in;
          pend_v_d    = 1'b1;
          overrun_d   = overrun_q | pend_v_q;
        end
      end

      S_DONE: begin
        if (valid_q && bus.depth_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
          if (pend_v_q) begin
            // Pending entry goes first; a simultaneous strobe refills the slot
            // without counting as an overrun because the slot is being drained.
            start       = 1'b1;
            start_disp  = pend_disp_q;
            pend_v_d    = bus.d_valid;
            if (bus.d_valid) begin
              pend_disp_d = bus.d_in;
            end
          end else if (bus.d_valid) begin
            start = 1'b1;
          end
        end else if (bus.d_valid) begin
          pend_disp_d = bus.d_in;
          pend_v_d    = 1'b1;
          overrun_d   = overrun_q | pend_v_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start) begin
      if (start_disp == 8'd0) begin
        // Zero disparity means infinite depth: no division, result is immediate
        state_d      = S_DONE;
        valid_d      = 1'b1;
        depth_d      = DEPTH_MAX;
        depth_disp_d = 8'd0;
        sat_d        = 1'b1;
        zero_d       = 1'b1;
      end else begin
        state_d = S_DIV;
        rem_d   = '0;
        dvd_d   = K_CONST;
        div_d   = start_disp;
        quo_d   = '0;
        cnt_d   = '0;
      end
    end
  end

  // State and datapath registers; reset aborts any conversion and drops the pending slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pend_disp_q  <= '0;
      pend_v_q     <= 1'b0;
      overrun_q    <= 1'b0;
      rem_q        <= '0;
      dvd_q        <= '0;
      div_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      depth_q      <= '0;
      depth_disp_q <= '0;
      sat_q        <= 1'b0;
      zero_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous state, independent of statement order.
      state_q      <= state_d;
      pend_disp_q  <= pend_disp_d;
      pend_v_q     <= pend_v_d;
      overrun_q    <= overrun_d;
      rem_q        <= rem_d;
      dvd_q        <= dvd_d;
      div_q        <= div_d;
      quo_q        <= quo_d;
      cnt_q        <= cnt_d;
      depth_q      <= depth_d;
      depth_disp_q <= depth_disp_d;
      sat_q        <= sat_d;
      zero_q       <= zero_d;
      valid_q      <= valid_d;
    end
  end

  assign bus.depth       = depth_q;
  assign bus.depth_d     = depth_disp_q;
  assign bus.depth_sat   = sat_q;
  assign bus.depth_zero  = zero_q;
  assign bus.depth_valid = valid_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_disparity_depth_conv.sv
// Self-checking bench for disparity_depth_conv: a transaction-level model
// (busy timer, one pending slot, K/d arithmetic) is compared against the DUT
// on every falling edge, plus directed scenarios with hand-computed results.
module tb_disparity_depth_conv;

  localparam int K_WIDTH = 24;
  localparam int K_VALUE = 245760;
  localparam int QW      = 16;
  localparam int LAT     = K_WIDTH + 1;
  localparam int QMAX    = (1 << QW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  disparity_depth_conv_if #(.QW(QW)) bus ();

  disparity_depth_conv #(
    .K_WIDTH (K_WIDTH),
    .K_VALUE (K_VALUE),
    .QW      (QW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int            m_busy   = 0;   // cycles of division still to run
  logic [7:0]    m_cur    = '0;  // disparity being divided
  bit            m_valid  = 1'b0;
  logic [QW-1:0] m_depth  = '0;
  logic [7:0]    m_disp   = '0;
  bit            m_sat    = 1'b0;
  bit            m_zero   = 1'b0;
  bit            m_pend_v = 1'b0;
  logic [7:0]    m_pend   = '0;
  bit            m_ovr    = 1'b0;
  logic [7:0]    m_tmp;

  function automatic void m_post(input logic [7:0] d);
    int q;
    m_valid = 1'b1;
    m_disp  = d;
    if (d == 8'd0) begin
      m_depth = '1;
      m_sat   = 1'b1;
      m_zero  = 1'b1;
    end else begin
      q      = K_VALUE / int'(d);
      m_zero = 1'b0;
      if (q > QMAX) begin
        m_depth = '1;
        m_sat   = 1'b1;
      end else begin
        m_depth = QW'(q);
        m_sat   = 1'b0;
      end
    end
  endfunction

  function automatic void m_start(input logic [7:0] d);
    if (d == 8'd0) m_post(d);
    else begin
      m_busy = K_WIDTH;
      m_cur  = d;
    end
  endfunction

  function automatic void m_capture(input logic [7:0] d);
    if (m_pend_v) m_ovr = 1'b1;
    m_pend   = d;
    m_pend_v = 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_valid = 1'b0; m_depth = '0; m_disp = '0;
      m_sat = 1'b0; m_zero = 1'b0; m_pend_v = 1'b0; m_pend = '0; m_ovr = 1'b0;
    end else if (m_busy > 0) begin
      if (bus.d_valid) m_capture(bus.d_in);
      m_busy--;
      if (m_busy == 0) m_post(m_cur);
    end else if (m_valid) begin
      if (bus.depth_ready) begin
        m_valid = 1'b0;
        if (m_pend_v) begin
          m_tmp = m_pend;
          if (bus.d_valid) m_pend = bus.d_in;
          else m_pend_v = 1'b0;
          m_start(m_tmp);
        end else if (bus.d_valid) begin
          m_start(bus.d_in);
        end
      end else if (bus.d_valid) begin
        m_capture(bus.d_in);
      end
    end else if (bus.d_valid) begin
      m_start(bus.d_in);
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid",   bus.depth_valid, 0);
      check("rst_depth",   bus.depth,       0);
      check("rst_depth_d", bus.depth_d,     0);
      check("rst_sat",     bus.depth_sat,   0);
      check("rst_zero",    bus.depth_zero,  0);
      check("rst_overrun", bus.overrun,     0);
    end else begin
      check("m_valid", bus.depth_valid, m_valid);
      if (m_valid) begin
        check("m_depth",   bus.depth,      m_depth);
        check("m_depth_d", bus.depth_d,    m_disp);
        check("m_sat",     bus.depth_sat,  m_sat);
        check("m_zero",    bus.depth_zero, m_zero);
      end
      check("m_overrun", bus.overrun, m_ovr);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic strobe(input logic [7:0] d);
    @(negedge clk);
    bus.d_in    = d;
    bus.d_valid = 1'b1;
    @(negedge clk);
    bus.d_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.depth_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_seen"}, bus.depth_valid, 1);
  endtask

  // Strobe d with ready high, measure cycles to depth_valid, check literal result
  task automatic run_one(input logic [7:0] d, input int exp_depth, input int exp_sat,
                         input int exp_zero, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.depth_ready = 1'b1;
    bus.d_in        = d;
    bus.d_valid     = 1'b1;
    @(negedge clk);
    bus.d_valid = 1'b0;
    lat = 1;
    while (!bus.depth_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("lat_d%0d", d),   lat,            exp_lat);
    check($sformatf("depth_d%0d", d), bus.depth,      exp_depth);
    check($sformatf("disp_d%0d", d),  bus.depth_d,    d);
    check($sformatf("sat_d%0d", d),   bus.depth_sat,  exp_sat);
    check($sformatf("zero_d%0d", d),  bus.depth_zero, exp_zero);
  endtask

  initial begin
    int lat;
    bus.d_in        = '0;
    bus.d_valid     = 1'b0;
    bus.depth_ready = 1'b0;

    // Reset held while d_valid toggles: outputs must stay at reset values
    repeat (6) begin
      @(negedge clk);
      bus.d_valid = ~bus.d_valid;
      bus.d_in    = 8'($urandom_range(1, 255));
    end
    @(negedge clk);
    bus.d_valid = 1'b0;
    #2 rst_n = 1'b1;

    // Basic conversions with ready high
    run_one(8'd64,  3840,  0, 0, LAT);
    run_one(8'd255, 963,   0, 0, LAT);
    run_one(8'd63,  3900,  0, 0, LAT);
    run_one(8'd1,   65535, 1, 0, LAT);
    run_one(8'd4,   61440, 0, 0, LAT);
    run_one(8'd0,   65535, 1, 1, 1);

    // Backpressure: second strobe during DIV lands in pend, first result held
    @(negedge clk);
    bus.depth_ready = 1'b0;
    strobe(8'd10);
    repeat (4) @(negedge clk);
    strobe(8'd20);
    wait_valid("bp1");
    check("bp1_depth", bus.depth, 24576);
    repeat (5) begin
      @(negedge clk);
      check("bp1_hold_depth", bus.depth, 24576);
      check("bp1_hold_valid", bus.depth_valid, 1);
    end
    bus.depth_ready = 1'b1;
    @(negedge clk);
    wait_valid("bp2");
    check("bp2_depth",   bus.depth,   12288);
    check("bp2_disp",    bus.depth_d, 20);
    check("bp2_overrun", bus.overrun, 0);

    // Third strobe before release: newest wins and overrun sticks
    @(negedge clk);
    bus.depth_ready = 1'b0;
    strobe(8'd10);
    repeat (3) @(negedge clk);
    strobe(8'd20);
    repeat (3) @(negedge clk);
    strobe(8'd40);
    check("ovr_set", bus.overrun, 1);
    wait_valid("ovr1");
    check("ovr1_depth", bus.depth, 24576);
    bus.depth_ready = 1'b1;
    @(negedge clk);
    wait_valid("ovr2");
    check("ovr2_depth",   bus.depth,   6144);
    check("ovr2_disp",    bus.depth_d, 40);
    check("ovr2_overrun", bus.overrun, 1);

    // Strobe coincident with the handshake, pend empty
    @(negedge clk);
    bus.depth_ready = 1'b0;
    strobe(8'd64);
    wait_valid("co1");
    bus.depth_ready = 1'b1;
    bus.d_in        = 8'd128;
    bus.d_valid     = 1'b1;
    @(negedge clk);
    bus.d_valid = 1'b0;
    check("co_valid_fall", bus.depth_valid, 0);
    lat = 1;
    while (!bus.depth_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("co_lat",   lat,         LAT);
    check("co_depth", bus.depth,   1920);
    check("co_disp",  bus.depth_d, 128);

    // Reset during DIV cycle 10
    strobe(8'd50);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid",   bus.depth_valid, 0);
    check("mid_rst_depth",   bus.depth,       0);
    check("mid_rst_overrun", bus.overrun,     0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_one(8'd50, 4915, 0, 0, LAT);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      bus.depth_ready = ($urandom_range(0, 9) < 7);
      bus.d_valid     = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 5))
        0:       bus.d_in = 8'd0;
        1:       bus.d_in = 8'd1;
        2:       bus.d_in = 8'd255;
        3:       bus.d_in = 8'($urandom_range(2, 4));
        default: bus.d_in = 8'($urandom);
      endcase
    end

    // Drain
    @(negedge clk);
    bus.d_valid     = 1'b0;
    bus.depth_ready = 1'b1;
    repeat (80) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/disparity_depth_conv.md
# disparity_depth_conv

Downstream stage of the disparity search: takes the 8-bit best-match disparity index produced by the comparator tree, together with its valid strobe, and converts it to a 16-bit depth value, depth = K / d, using a bit-serial restoring divider. The stage absorbs the search pipeline's lack of backpressure with a one-entry pending register. It presents results to the next consumer over a valid/ready handshake.

## Interface
- K_WIDTH, 24: width of the depth constant K (focal length × baseline, fixed-point); it is also the divider iteration count.
- K_VALUE, 245760: depth constant K; must fit in K_WIDTH bits.
- QW, 16: output depth width.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- d_in  in  8  disparity index from the comparator tree.
- d_valid  in  1  one-cycle strobe; d_in is valid in this cycle. No backpressure is possible.
- depth  out  QW  quotient floor(K_VALUE / d), saturated.
- depth_d  out  8  disparity that produced the current depth.
- depth_sat  out  1  quotient exceeded 2^QW−1, or d was 0.
- depth_zero  out  1  d was 0 (infinite depth).
- depth_valid  out  1  result available.
- depth_ready  in  1  consumer accepts the result.
- overrun  out  1  sticky: a pending disparity was overwritten. Cleared only by reset.

## Operation
- States:
  - IDLE: no work in progress.
  - DIV: divider iterating.
  - DONE: result held on the outputs.
- Pending register (pend_d, pend_v):
  - d_valid in IDLE is consumed directly.
  - d_valid in DIV or DONE writes pend_d and sets pend_v.
  - If pend_v is already 1, pend_d is overwritten (newest wins) and overrun is set.
- Start of a conversion, from d_in in IDLE or from pend_d:
  - d ≠ 0: rem=0, dividend=K_VALUE, divisor=d, cnt=0, go to DIV.
  - d = 0: depth=2^QW−1, depth_sat=1, depth_zero=1, go to DONE directly.
- DIV, each cycle:
  - rem' = {rem, dividend MSB}; dividend shifts left.
  - If rem' ≥ divisor: rem' −= divisor and shift 1 into the quotient; otherwise shift 0.
  - cnt increments. When cnt reaches K_WIDTH−1, go to DONE.
- Width rules:
  - rem is 9 bits; quotient is K_WIDTH bits.
  - At the DONE transition, if quotient[K_WIDTH−1:QW] ≠ 0: depth=2^QW−1 and depth_sat=1. Otherwise depth=quotient[QW−1:0] and depth_sat=0.
- DONE: outputs held stable while depth_valid=1 and depth_ready=0. When depth_valid & depth_ready:
  - If pend_v: start from pend_d (same cycle), clear pend_v.
  - Otherwise, if d_valid: start from d_in.
  - Otherwise: go to IDLE.
- Simultaneous events:
  - d_valid in the handshake cycle while pend_v=1: pend_d is started; d_in goes into pend_d with pend_v kept at 1; no overrun.
  - d_valid in the handshake cycle while pend_v=0: d_in starts immediately.
- Reset mid-operation aborts the conversion and drops pend.

## Timing
- Reset values:
  - state=IDLE, pend_v=0.
  - depth=0, depth_d=0, depth_sat=0, depth_zero=0, depth_valid=0, overrun=0.
- d_valid high in cycle N while IDLE: DIV occupies cycles N+1 … N+K_WIDTH. depth_valid is high from cycle N+K_WIDTH+1, so latency is K_WIDTH+1 (25 by default).
- d = 0: depth_valid is high in cycle N+1.
- depth_valid falls the cycle after the handshake, unless a zero-disparity start makes the next result valid immediately.
- Throughput with depth_ready held high: one result per K_WIDTH+1 cycles.

## Test plan
- Reset with d_valid toggling → all outputs 0 and state IDLE until rst_n rises.
- d_in=64, depth_ready=1 → depth=3840, sat=0, depth_valid exactly 25 cycles after the strobe. Also d_in=255 → 963, and d_in=63 → 3900.
- d_in=1 → depth=65535, depth_sat=1, depth_zero=0. d_in=0 → depth=65535, sat=1, zero=1, valid one cycle later.
- depth_ready=0 with strobes d=10 and d=20 during DIV → first result (24576) held stable. Release ready → second result 12288, overrun=0. A third strobe before release → overrun=1, and pend holds the newest value.
- Strobe coincident with the handshake, pend empty → new conversion starts that cycle, next depth_valid 25 cycles later.
- rst_n asserted at DIV cycle 10 → outputs return to reset values immediately. A fresh strobe after release converts correctly.
